enc16to4_seq: RTL



---
 rtl/enc16to4_seq_pkg.sv | 18 +
 rtl/enc16to4_seq_lsb_find16.sv | 32 +++
 rtl/enc16to4_seq.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/enc16to4_seq_pkg.sv
// -----------------------------------------------------------------------------
// enc_pkg
// Shared constants and the FSM state type for the sequential 16-to-4 encoder.
//   ENC_N       : request vector width (16)
//   ENC_IDX_W   : encoded index width (log2 of ENC_N)
//   enc_state_t : ENC_IDLE waits for a vector, ENC_EMIT streams its indices
// -----------------------------------------------------------------------------
package enc_pkg;

  localparam int ENC_N     = 16;
  localparam int ENC_IDX_W = 4;

  typedef enum logic [0:0] {
    ENC_IDLE = 1'b0,
    ENC_EMIT = 1'b1
  } enc_state_t;

endpackage : enc_pkg

// File: rtl/enc16to4_seq_lsb_find16.sv
// -----------------------------------------------------------------------------
// lsb_find16
// Combinational lowest-set-bit finder over a 16-bit vector indexed [0:15].
// Ports:
//   vec    in  [0:15] vector to scan; vec[k] set means index k is present
//   idx    out [3:0]  lowest k with vec[k] set (0 when vec is all-zero)
//   any    out        at least one bit of vec is set
//   single out        exactly one bit of vec is set
// -----------------------------------------------------------------------------
module lsb_find16 (
  input  logic [0:15] vec,
  output logic [3:0]  idx,
  output logic        any,
  output logic        single
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx = '0;
    for (int k = 15; k >= 0; k--) begin
      if (vec[k]) begin
        idx = 4'(k);
      end
    end
  end

  // x & (x - 1) clears exactly one set bit, so a zero result with x nonzero
  // means a single bit was set; this holds regardless of bit numbering.
  assign any    = |vec;
  assign single = any && ((vec & (vec - 16'd1)) == 16'd0);

endmodule : lsb_find16

// File: rtl/enc16to4_seq.sv
// -----------------------------------------------------------------------------
// enc16to4_seq
// Sequential 16-to-4 encoder. Accepts a request vector on a valid/ready
// handshake and streams the index of every set bit, lowest first, one beat
// per set bit. An all-zero vector yields a single marker beat (out_none=1).
//
// Configuration macro: ENC_MULTIHOT_FLAG_EN adds the multi_hot output, a
// one-cycle registered pulse in the cycle after acceptance of a vector with
// more than one bit set.
//
// Ports:
//   clk        in         rising-edge clock
//   rst_n      in         synchronous active-low reset
//   en         in         enable; gates acceptance of new vectors only
//   in_valid   in         a request vector is offered
//   in_ready   out        a vector can be accepted this cycle
//   y          in [0:N-1] request vector, y[k] set requests index k
//   out_valid  out        current beat on w is valid (registered)
//   out_ready  in         consumer accepts the current beat
//   w          out [IDX_W-1:0] index of the current beat (registered)
//   out_last   out        final beat of the vector (registered)
//   out_none   out        marker beat for an all-zero vector (registered)
//   multi_hot  out        multi-hot pulse (only with ENC_MULTIHOT_FLAG_EN)
// -----------------------------------------------------------------------------
module enc16to4_seq
  import enc_pkg::*;
#(
  parameter int N     = ENC_N,
  parameter int IDX_W = ENC_IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:N-1]     y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] w,
  output logic             out_last,
  output logic             out_none
`ifdef ENC_MULTIHOT_FLAG_EN
  ,
  output logic             multi_hot
`endif
);

  enc_state_t       state;
  enc_state_t       state_nxt;
  logic [0:N-1]     pending;
  logic [0:N-1]     pend_clr;
  logic [0:N-1]     find_in;
  logic [IDX_W-1:0] f_idx;
  logic             f_any;
  logic             f_single;
  logic             accept;
  logic             fire;

  // Remove the index currently on w from the pending set.
  function automatic logic [0:N-1] clear_bit(input logic [0:N-1]     vec,
                                             input logic [IDX_W-1:0] pos);
    logic [0:N-1] r;
    r = vec;
    for (int k = 0; k < N; k++) begin
      if (IDX_W'(k) == pos) begin
        r[k] = 1'b0;
      end
    end
    return r;
  endfunction

  // A single finder serves both cases: in IDLE it scans the incoming vector
  // to produce the first beat; in EMIT it scans what remains after the
  // current beat, so the next beat is ready in the register on the handshake.
  lsb_find16 u_find (
    .vec    (find_in),
    .idx    (f_idx),
    .any    (f_any),
    .single (f_single)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ENC_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ENC_IDLE: if (accept)            state_nxt = ENC_EMIT;
      ENC_EMIT: if (fire && out_last)  state_nxt = ENC_IDLE;
      default:                         state_nxt = ENC_IDLE;
    endcase
  end

  // Output / handshake logic
  always_comb begin
    in_ready = rst_n && en && (state == ENC_IDLE);
    accept   = in_valid && in_ready;
    fire     = out_valid && out_ready;
    pend_clr = clear_bit(pending, w);
    find_in  = (state == ENC_IDLE) ? y : pend_clr;
  end

  // ---- stage boundary: registered beat outputs and pending set ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending   <= '0;
      out_valid <= 1'b0;
      w         <= '0;
      out_last  <= 1'b0;
      out_none  <= 1'b0;
    end else if (accept) begin
      pending   <= y;
      out_valid <= 1'b1;
      w         <= f_idx;
      // An all-zero vector is its own single, final marker beat.
      out_last  <= f_single || !f_any;
      out_none  <= !f_any;
    end else if (fire) begin
      pending   <= pend_clr;
      out_valid <= !out_last;
      w         <= f_idx;
      out_last  <= f_single;
      out_none  <= 1'b0;
    end
  end

`ifdef ENC_MULTIHOT_FLAG_EN
  // More than one bit set is exactly "some bit set but not a single one".
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      multi_hot <= 1'b0;
    end else begin
      multi_hot <= accept && f_any && !f_single;
    end
  end
`endif

endmodule : enc16to4_seq
